// File: rtl/spi_ctrl_pkg.sv
// spi_ctrl_pkg -- shared definitions for the SPI command sequencer.
//   Op encoding of the command byte's top two bits, FSM state encoding,
//   command field geometry and the register-address range check.
package spi_ctrl_pkg;

  // Command layout: op = cmd[CMD_W-1 -: OP_W], addr = cmd[CMD_W-OP_W-1:0]
  localparam int OP_W = 2;

  localparam logic [OP_W-1:0] OP_NOP    = 2'b00;
  localparam logic [OP_W-1:0] OP_WR     = 2'b01;
  localparam logic [OP_W-1:0] OP_RD     = 2'b10;
  localparam logic [OP_W-1:0] OP_STREAM = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_WAIT,
    RD_FETCH,
    RD_WAIT,
    STREAM
  } state_t;

  function automatic int addr_w(input int cmd_w);
    return cmd_w - OP_W;
  endfunction

  function automatic logic addr_valid(input int addr, input int num_regs);
    return addr < num_regs;
  endfunction

endpackage

// File: rtl/spi_ctrl_timer.sv
// spi_ctrl_timer -- watchdog between a command frame and its data frame.
//   Only built with SPI_CTRL_TIMEOUT_EN defined.
// Ports:
//   clk, rst  clock, async active-high reset
//   run       controller is waiting for a data frame
//   restart   a new command arrived; start counting again
//   expired   TIMEOUT_CYC cycles spent waiting
`ifdef SPI_CTRL_TIMEOUT_EN
module spi_ctrl_timer #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  // cnt is 0 in the first waiting cycle, so expired fires in the
  // TIMEOUT_CYC-th waiting cycle and the FSM is back in IDLE right after.
  assign expired = run && (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt <= '0;
    else if (!run || restart) cnt <= '0;
    else if (!expired)       cnt <= cnt + CW'(1);
  end

endmodule
`endif

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl -- command/transaction sequencer behind the SPI slave.
//   Decodes each command byte and routes the next data frame to a register
//   write, a register readback (into tx_data) or a FIFO stream.
//   Optional macro: SPI_CTRL_TIMEOUT_EN adds a wait-for-data watchdog.
// Ports:
//   clk, rst               clock, async active-high reset
//   cmd_in, cmd_done       received command + completion pulse
//   rx_data, data_done     received data word + completion pulse
//   tx_data                word shifted out in the next data frame
//   reg_addr/wr_en/wdata   register bank write port (addr shared with read)
//   reg_rd_en, reg_rdata   register bank read, data 1 cycle after strobe
//   fifo_rd_en/rdata/empty stream FIFO pop, data 1 cycle after strobe
//   busy                   not IDLE
//   err                    sticky error, cleared by NOP or reset
module spi_cmd_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int                DATA_W      = 16,
  parameter int                CMD_W       = 8,
  parameter int                NUM_REGS    = 32,
  parameter logic [DATA_W-1:0] BAD_WORD    = 16'hDEAD,
  parameter logic [DATA_W-1:0] EMPTY_WORD  = 16'h0000,
  parameter int                TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CMD_W-1:0]  cmd_in,
  input  logic              cmd_done,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              data_done,
  output logic [DATA_W-1:0] tx_data,
  output logic [CMD_W-3:0]  reg_addr,
  output logic              reg_wr_en,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_rd_en,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rdata,
  input  logic              fifo_empty,
  output logic              busy,
  output logic              err
);

  localparam int AW = addr_w(CMD_W);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] tx_nxt, wdata_nxt;
  logic [AW-1:0]     addr_nxt;
  logic              wr_nxt, rd_nxt, pop_nxt, err_nxt;
  logic              rd_ph, rd_ph_nxt;
  // [0] pop strobe in flight, [1] FIFO data returning this cycle
  logic [1:0]        vld_pipe;

  logic [OP_W-1:0]   cmd_op;
  logic [AW-1:0]     cmd_addr;
  logic              cmd_ok, reg_ok, pf_busy, tmo;

  assign cmd_op   = cmd_in[CMD_W-1 -: OP_W];
  assign cmd_addr = cmd_in[AW-1:0];
  assign cmd_ok   = addr_valid(32'(cmd_addr), NUM_REGS);
  assign reg_ok   = addr_valid(32'(reg_addr), NUM_REGS);
  assign pf_busy  = |vld_pipe;

  assign fifo_rd_en = vld_pipe[0];
  assign busy       = (state != IDLE);

`ifdef SPI_CTRL_TIMEOUT_EN
  logic wait_st;
  assign wait_st = (state == WR_WAIT) || (state == RD_WAIT);

  spi_ctrl_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (wait_st),
    .restart (cmd_done),
    .expired (tmo)
  );
`else
  // Never true for any sensible TIMEOUT_CYC: without the timer the wait
  // states hold until the data frame or a new command.
  assign tmo = (TIMEOUT_CYC < 0);
`endif

  always_comb begin
    state_nxt = state;
    tx_nxt    = tx_data;
    addr_nxt  = reg_addr;
    wdata_nxt = reg_wdata;
    err_nxt   = err;
    wr_nxt    = 1'b0;
    rd_nxt    = 1'b0;
    pop_nxt   = 1'b0;
    rd_ph_nxt = 1'b0;

    // A pop issued last cycle lands in tx_data now.
    if (vld_pipe[1]) tx_nxt = fifo_rdata;

    if (cmd_done) begin
      // Abandoning a transaction that was waiting on data is an error;
      // so is a data frame lost to a simultaneous command.
      if ((state == WR_WAIT) || (state == RD_WAIT) ||
          (data_done && (state != IDLE) && (state != STREAM)))
        err_nxt = 1'b1;
      addr_nxt = cmd_addr;
      case (cmd_op)
        OP_NOP: begin
          err_nxt   = 1'b0;
          state_nxt = IDLE;
        end
        OP_WR:  state_nxt = WR_WAIT;
        OP_RD: begin
          state_nxt = RD_FETCH;
          rd_nxt    = cmd_ok;
        end
        default: begin
          state_nxt = STREAM;
          if (!pf_busy) begin
            if (!fifo_empty) pop_nxt = 1'b1;
            else             tx_nxt  = EMPTY_WORD;
          end
        end
      endcase
    end else if (tmo) begin
      state_nxt = IDLE;
      err_nxt   = 1'b1;
    end else begin
      case (state)
        WR_WAIT: if (data_done) begin
          state_nxt = IDLE;
          if (reg_ok) begin
            wr_nxt    = 1'b1;
            wdata_nxt = rx_data;
          end else begin
            err_nxt = 1'b1;
          end
        end
        // Phase 0: read strobe is out. Phase 1: bank data is valid.
        RD_FETCH: if (!rd_ph) begin
          rd_ph_nxt = 1'b1;
        end else begin
          tx_nxt    = reg_ok ? reg_rdata : BAD_WORD;
          err_nxt   = err | !reg_ok;
          state_nxt = RD_WAIT;
        end
        RD_WAIT: if (data_done) state_nxt = IDLE;
        STREAM: if (data_done && !pf_busy) begin
          if (!fifo_empty) pop_nxt = 1'b1;
          else             tx_nxt  = EMPTY_WORD;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tx_data   <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      err       <= 1'b0;
      rd_ph     <= 1'b0;
      vld_pipe  <= '0;
    end else begin
      state     <= state_nxt;
      tx_data   <= tx_nxt;
      reg_addr  <= addr_nxt;
      reg_wdata <= wdata_nxt;
      reg_wr_en <= wr_nxt;
      reg_rd_en <= rd_nxt;
      err       <= err_nxt;
      rd_ph     <= rd_ph_nxt;
      vld_pipe  <= {vld_pipe[0], pop_nxt};
    end
  end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
module tb_spi_cmd_ctrl;
  localparam int DW = 16;
  localparam int CW = 8;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] cmd_in = '0;
  logic          cmd_done = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          data_done = 1'b0;
  logic [DW-1:0] tx_data, reg_wdata, reg_rdata, fifo_rdata;
  logic [CW-3:0] reg_addr;
  logic          reg_wr_en, reg_rd_en, fifo_rd_en, fifo_empty, busy, err;

  spi_cmd_ctrl #(.DATA_W(DW), .CMD_W(CW), .NUM_REGS(NR), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst(rst), .cmd_in(cmd_in), .cmd_done(cmd_done),
    .rx_data(rx_data), .data_done(data_done), .tx_data(tx_data),
    .reg_addr(reg_addr), .reg_wr_en(reg_wr_en), .reg_wdata(reg_wdata),
    .reg_rd_en(reg_rd_en), .reg_rdata(reg_rdata), .fifo_rd_en(fifo_rd_en),
    .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // register bank: read data one cycle after the strobe
  logic [DW-1:0] bank [NR];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) bank[i] <= '0;
      reg_rdata <= '0;
    end else begin
      if (reg_wr_en && 32'(reg_addr) < NR) bank[reg_addr[4:0]] <= reg_wdata;
      if (reg_rd_en) reg_rdata <= bank[reg_addr[4:0]];
    end
  end

  // stream FIFO: memory written by the stimulus, popped by the DUT
  logic [DW-1:0] fmem [256];
  int wp = 0, rp = 0;
  initial fifo_rdata = '0;
  assign fifo_empty = (wp == rp);
  always @(posedge clk) begin
    if (fifo_rd_en && wp != rp) begin
      fifo_rdata <= fmem[rp[7:0]];
      rp <= rp + 1;
    end
  end

  int wr_cnt = 0, rd_cnt = 0, pop_cnt = 0;
  always @(posedge clk) begin
    if (reg_wr_en)  wr_cnt  <= wr_cnt + 1;
    if (reg_rd_en)  rd_cnt  <= rd_cnt + 1;
    if (fifo_rd_en) pop_cnt <= pop_cnt + 1;
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [DW-1:0] exp_bank [NR];
  logic          exp_err = 1'b0;
  logic [DW-1:0] fq [$];
  int            npop;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input logic [CW-1:0] c);
    cmd_in = c; cmd_done = 1'b1; tick(); cmd_done = 1'b0;
  endtask

  task automatic send_data(input logic [DW-1:0] d);
    rx_data = d; data_done = 1'b1; tick(); data_done = 1'b0;
  endtask

  task automatic send_both(input logic [CW-1:0] c, input logic [DW-1:0] d);
    cmd_in = c; rx_data = d; cmd_done = 1'b1; data_done = 1'b1;
    tick(); cmd_done = 1'b0; data_done = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] d, input bit model);
    fmem[wp[7:0]] = d; wp++;
    if (model) fq.push_back(d);
  endtask

  // a prefetch pops when anything is queued, else presents the empty word
  function automatic logic [DW-1:0] next_word();
    if (fq.size() > 0) begin npop++; return fq.pop_front(); end
    return 16'h0000;
  endfunction

  task automatic do_write(input logic [5:0] a, input logic [DW-1:0] d, input bit both);
    int w0; logic ok;
    ok = (a < NR);
    if (both) send_both({2'b01, a}, 16'(~d)); else send_cmd({2'b01, a});
    repeat ($urandom_range(0, 3)) tick();
    w0 = wr_cnt;
    send_data(d);
    chk("rw_en", reg_wr_en, ok);
    if (ok) begin
      chk("rw_addr", reg_addr, a);
      chk("rw_data", reg_wdata, d);
      exp_bank[a[4:0]] = d;
    end else exp_err = 1'b1;
    tick();
    chk("rw_cnt", wr_cnt - w0, ok);
    chk("rw_err", err, exp_err);
    chk("rw_busy", busy, 0);
  endtask

  task automatic do_read(input logic [5:0] a);
    int r0; logic ok;
    ok = (a < NR);
    r0 = rd_cnt;
    send_cmd({2'b10, a});
    chk("rr_en", reg_rd_en, ok);
    tick(); tick();
    chk("rr_tx", tx_data, ok ? exp_bank[a[4:0]] : 16'hDEAD);
    if (!ok) exp_err = 1'b1;
    chk("rr_err", err, exp_err);
    send_data(16'($urandom));
    chk("rr_busy", busy, 0);
    chk("rr_cnt", rd_cnt - r0, ok);
  endtask

  task automatic do_stream();
    int p0, n, m;
    n = $urandom_range(0, 3);
    m = $urandom_range(1, 4);
    for (int i = 0; i < n; i++) push(16'($urandom), 1'b1);
    p0 = pop_cnt; npop = 0;
    send_cmd({2'b11, 6'($urandom)});
    tick(); tick();
    chk("st_entry", tx_data, next_word());
    for (int f = 0; f < m; f++) begin
      send_data(16'($urandom));
      tick(); tick();
      chk("st_frame", tx_data, next_word());
    end
    tick();
    chk("st_pops", pop_cnt - p0, npop);
    chk("st_busy", busy, 1);
    send_cmd(8'h00);
    exp_err = 1'b0;
    chk("st_err", err, 0);
  endtask

  int w0, r0, p0, kind;
  logic [5:0] a1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_tx", tx_data, 0);   chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);      chk("rst_wr", reg_wr_en, 0);
    chk("rst_rd", reg_rd_en, 0); chk("rst_pop", fifo_rd_en, 0);
    chk("rst_addr", reg_addr, 0);
    rst = 1'b0;
    tick();

    // write
    send_cmd(8'h45);
    chk("wr_busy", busy, 1);
    tick(); tick();
    w0 = wr_cnt;
    send_data(16'h1234);
    chk("wr_en", reg_wr_en, 1); chk("wr_addr", reg_addr, 5);
    chk("wr_data", reg_wdata, 16'h1234); chk("wr_idle", busy, 0);
    tick();
    chk("wr_pulse", reg_wr_en, 0); chk("wr_cnt", wr_cnt - w0, 1);
    chk("wr_err", err, 0);

    // read of register 3 after loading it
    send_cmd(8'h43); send_data(16'hBEEF); tick();
    r0 = rd_cnt;
    send_cmd(8'h83);
    chk("rd_en", reg_rd_en, 1);
    tick();
    chk("rd_pulse", reg_rd_en, 0);
    tick();
    chk("rd_tx", tx_data, 16'hBEEF); chk("rd_busy", busy, 1);
    send_data(16'h0000);
    chk("rd_idle", busy, 0); chk("rd_hold", tx_data, 16'hBEEF);
    chk("rd_cnt", rd_cnt - r0, 1);

    // invalid read, then NOP
    r0 = rd_cnt;
    send_cmd(8'hBF);
    chk("bad_rd_en", reg_rd_en, 0);
    tick(); tick();
    chk("bad_tx", tx_data, 16'hDEAD); chk("bad_err", err, 1);
    send_data(16'h0000);
    chk("bad_cnt", rd_cnt - r0, 0);
    send_cmd(8'h00);
    chk("nop_err", err, 0); chk("nop_busy", busy, 0);

    // stream of two words then empty
    push(16'h00A1, 1'b0); push(16'h00A2, 1'b0);
    p0 = pop_cnt;
    send_cmd(8'hC0);
    chk("st0_pop", fifo_rd_en, 1);
    tick(); tick();
    chk("st0_a1", tx_data, 16'h00A1);
    send_data(16'h0000);
    chk("st1_pop", fifo_rd_en, 1);
    tick(); tick();
    chk("st1_a2", tx_data, 16'h00A2);
    send_data(16'h0000);
    chk("st2_nopop", fifo_rd_en, 0); chk("st2_empty", tx_data, 16'h0000);
    tick(); tick();
    chk("st_cnt", pop_cnt - p0, 2); chk("st_busy", busy, 1);
    send_cmd(8'h00);

    // write aborted by a read
    w0 = wr_cnt;
    send_cmd(8'h45); tick();
    send_cmd(8'h83);
    chk("ab_err", err, 1); chk("ab_rd", reg_rd_en, 1);
    tick(); tick();
    chk("ab_tx", tx_data, 16'hBEEF);
    send_data(16'h9999); tick();
    chk("ab_nowr", wr_cnt - w0, 0);
    send_cmd(8'h00);

    // command and data in the same cycle: data dropped
    send_cmd(8'h45);
    send_both(8'h46, 16'h5555);
    chk("cd_err", err, 1); chk("cd_nowr", reg_wr_en, 0); chk("cd_busy", busy, 1);
    send_data(16'h6666);
    chk("cd_wr", reg_wr_en, 1); chk("cd_addr", reg_addr, 6); chk("cd_data", reg_wdata, 16'h6666);
    send_cmd(8'h00);

    // data frame in IDLE is ignored; write to invalid address
    w0 = wr_cnt;
    send_data(16'h7777);
    chk("idle_wr", reg_wr_en, 0); chk("idle_busy", busy, 0);
    send_cmd(8'h7F); send_data(16'h1111);
    chk("badwr_en", reg_wr_en, 0); chk("badwr_err", err, 1);
    tick();
    chk("idle_cnt", wr_cnt - w0, 0);
    send_cmd(8'h00);

    // asynchronous reset in the middle of a write
    send_cmd(8'h45); send_cmd(8'h45);
    chk("pre_rst_err", err, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0); chk("arst_err", err, 0); chk("arst_wr", reg_wr_en, 0);
    #2 rst = 1'b0;
    tick();
    w0 = wr_cnt;
    send_data(16'h4242); tick();
    chk("arst_nowr", wr_cnt - w0, 0);
    for (int i = 0; i < NR; i++) exp_bank[i] = '0;

`ifdef SPI_CTRL_TIMEOUT_EN
    w0 = wr_cnt;
    send_cmd(8'h45);
    repeat (99) tick();
    chk("tmo_wait", busy, 1);
    tick();
    chk("tmo_idle", busy, 0); chk("tmo_err", err, 1);
    send_data(16'hABCD); tick();
    chk("tmo_nowr", wr_cnt - w0, 0);
    send_cmd(8'h00);
`endif

    // randomized transactions against the model
    exp_err = 1'b0;
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 5);
      a1 = 6'($urandom_range(0, 63));
      case (kind)
        0: begin send_cmd(8'h00); exp_err = 1'b0; chk("r_nop", err, 0); end
        1, 2: do_write(6'($urandom_range(0, 40)), 16'($urandom), 1'b0);
        3: do_read(6'($urandom_range(0, 40)));
        4: do_stream();
        default: begin
          if ($urandom_range(0, 1) == 1) begin
            send_cmd({2'b10, a1}); tick(); tick(); tick();
            if (a1 >= NR) exp_err = 1'b1;
          end else begin
            send_cmd({2'b01, a1}); tick();
          end
          exp_err = 1'b1;
          do_write(6'($urandom_range(0, 40)), 16'($urandom), 1'($urandom_range(0, 1)));
        end
      endcase
    end
    for (int i = 0; i < 4; i++) do_read(6'(i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
